// File: rtl/mips_trace_pkg.sv
// Shared definitions for the golden-trace checker: FSM encoding and the
// packing of a trace entry as {pc, wnum, wdata} (wdata in the low bits).
package mips_trace_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_FAIL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_PC_W   = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RNUM_W = 5;

  // Total width of one packed trace entry
  function automatic int entry_w(input int pc_w, input int rnum_w, input int data_w);
    return pc_w + rnum_w + data_w;
  endfunction

  // LSB of the register-number field inside a packed entry
  function automatic int wnum_lsb(input int data_w);
    return data_w;
  endfunction

  // LSB of the PC field inside a packed entry
  function automatic int pc_lsb(input int rnum_w, input int data_w);
    return rnum_w + data_w;
  endfunction

endpackage

// File: rtl/trace_ref_fifo.sv
// Golden-entry FIFO: one push and up to NUM_POP pops per cycle.
// The NUM_POP oldest entries are exposed in parallel so every writeback lane
// can be compared in the same cycle.
module trace_ref_fifo #(
  parameter int ENTRY_W = 69,
  parameter int DEPTH   = 8,
  parameter int NUM_POP = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push,
  input  logic [ENTRY_W-1:0]                  push_data,
  input  logic [$clog2(NUM_POP+1)-1:0]        pop_n,
  output logic [NUM_POP*ENTRY_W-1:0]          head,
  output logic [$clog2(DEPTH):0]              count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of 2)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CNT_W'(push) - CNT_W'(pop_n);
    end
  end

  // Storage write; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  for (genvar gi = 0; gi < NUM_POP; gi++) begin : g_head
    assign head[gi*ENTRY_W +: ENTRY_W] = mem[rd_ptr + AW'(gi)];
  end

endmodule

// File: rtl/mips_trace_checker.sv
// Compares each cycle's register-file writebacks against a golden trace.
// Writes to $0 are skipped; the remaining lanes are compacted onto the FIFO
// head entries in program order. Tracks counts, first-mismatch capture and
// end-of-test via a store of 0 to DONE_ADDR.
module mips_trace_checker
  import mips_trace_pkg::*;
#(
  parameter int PC_W             = DEF_PC_W,
  parameter int DATA_W           = DEF_DATA_W,
  parameter int RNUM_W           = DEF_RNUM_W,
  parameter int NUM_WB           = 2,
  parameter int REF_DEPTH        = 8,
  parameter int STOP_ON_MISMATCH = 1,
  parameter int DONE_ADDR        = 12
) (
  input  logic                     mips_cpu_clk,
  input  logic                     mips_cpu_resetn,
  input  logic                     ref_valid,
  output logic                     ref_ready,
  input  logic [PC_W-1:0]          ref_pc,
  input  logic [RNUM_W-1:0]        ref_wnum,
  input  logic [DATA_W-1:0]        ref_wdata,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*PC_W-1:0]   wb_pc,
  input  logic [NUM_WB*RNUM_W-1:0] wb_waddr,
  input  logic [NUM_WB*DATA_W-1:0] wb_wdata,
  output logic                     wb_ready,
  input  logic                     mem_wen,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  output logic                     done,
  output logic                     pass,
  output logic [15:0]              mismatch_cnt,
  output logic [31:0]              checked_cnt,
  output logic [PC_W-1:0]          cap_pc,
  output logic [PC_W-1:0]          cap_ref_pc,
  output logic [RNUM_W-1:0]        cap_waddr,
  output logic [RNUM_W-1:0]        cap_ref_wnum,
  output logic [DATA_W-1:0]        cap_wdata,
  output logic [DATA_W-1:0]        cap_ref_wdata
);

  localparam int ENTRY_W  = entry_w(PC_W, RNUM_W, DATA_W);
  localparam int WNUM_LSB = wnum_lsb(DATA_W);
  localparam int PC_LSB   = pc_lsb(RNUM_W, DATA_W);
  localparam int CNT_W    = $clog2(REF_DEPTH) + 1;
  localparam int CW       = $clog2(NUM_WB + 1);
  localparam int LW       = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

  state_t                    state;
  logic [CNT_W-1:0]          fifo_count;
  logic [NUM_WB*ENTRY_W-1:0] head_flat;
  logic [PC_W-1:0]           head_pc    [NUM_WB];
  logic [RNUM_W-1:0]         head_wnum  [NUM_WB];
  logic [DATA_W-1:0]         head_wdata [NUM_WB];
  logic [PC_W-1:0]           lane_pc    [NUM_WB];
  logic [RNUM_W-1:0]         lane_waddr [NUM_WB];
  logic [DATA_W-1:0]         lane_wdata [NUM_WB];
  logic [LW-1:0]             rank       [NUM_WB];
  logic [NUM_WB-1:0]         eff;
  logic [NUM_WB-1:0]         mism;
  logic [CW-1:0]             acc;
  logic [CW-1:0]             num_eff;
  logic [CW-1:0]             nmis;
  logic [LW-1:0]             first_lane;
  logic [CW-1:0]             pop_n;
  logic [16:0]               mis_sum;
  logic [15:0]               mis_next;
  logic                      accept;
  logic                      any_mis;
  logic                      done_store;
  logic                      push;

  assign push       = ref_valid && ref_ready;
  assign ref_ready  = (state == ST_RUN) && (fifo_count < CNT_W'(REF_DEPTH));
  assign wb_ready   = (fifo_count >= CNT_W'(num_eff)) || (state != ST_RUN);
  assign accept     = (state == ST_RUN) && (fifo_count >= CNT_W'(num_eff));
  assign pop_n      = accept ? num_eff : '0;
  assign any_mis    = accept && (mism != '0);
  assign done_store = mem_wen && (mem_addr == 32'(DONE_ADDR)) && (mem_wdata == 32'd0);
  assign mis_sum    = {1'b0, mismatch_cnt} + 17'(nmis);
  assign mis_next   = !accept ? mismatch_cnt : (mis_sum[16] ? 16'hFFFF : mis_sum[15:0]);

  trace_ref_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (REF_DEPTH),
    .NUM_POP (NUM_WB)
  ) u_fifo (
    .clk       (mips_cpu_clk),
    .rst_n     (mips_cpu_resetn),
    .push      (push),
    .push_data ({ref_pc, ref_wnum, ref_wdata}),
    .pop_n     (pop_n),
    .head      (head_flat),
    .count     (fifo_count)
  );

  // Per-lane field unpacking; each effective lane is matched to head entry rank[gi]
  for (genvar gi = 0; gi < NUM_WB; gi++) begin : g_lane
    assign head_pc[gi]    = head_flat[gi*ENTRY_W + PC_LSB   +: PC_W];
    assign head_wnum[gi]  = head_flat[gi*ENTRY_W + WNUM_LSB +: RNUM_W];
    assign head_wdata[gi] = head_flat[gi*ENTRY_W            +: DATA_W];
    assign lane_pc[gi]    = wb_pc[gi*PC_W +: PC_W];
    assign lane_waddr[gi] = wb_waddr[gi*RNUM_W +: RNUM_W];
    assign lane_wdata[gi] = wb_wdata[gi*DATA_W +: DATA_W];
    assign eff[gi]        = wb_valid[gi] && (lane_waddr[gi] != '0);
    assign mism[gi]       = eff[gi] && ((lane_pc[gi]    != head_pc[rank[gi]])   ||
                                        (lane_waddr[gi] != head_wnum[rank[gi]]) ||
                                        (lane_wdata[gi] != head_wdata[rank[gi]]));
  end

  // Lane compaction: rank of each lane among the effective lanes below it
  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      rank[i] = LW'(acc);
      acc     = acc + CW'(eff[i]);
    end
    num_eff = acc;
  end

  // Mismatch population count and lowest mismatching lane
  always_comb begin
    nmis       = '0;
    first_lane = '0;
    for (int i = NUM_WB - 1; i >= 0; i--) begin
      nmis = nmis + CW'(mism[i]);
      if (mism[i]) first_lane = LW'(i);
    end
  end

  // Counters and first-mismatch capture; only advance on accepted RUN cycles
  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_resetn) begin
    if (!mips_cpu_resetn) begin
      checked_cnt   <= '0;
      mismatch_cnt  <= '0;
      cap_pc        <= '0;
      cap_ref_pc    <= '0;
      cap_waddr     <= '0;
      cap_ref_wnum  <= '0;
      cap_wdata     <= '0;
      cap_ref_wdata <= '0;
    end else if (accept) begin
      checked_cnt  <= checked_cnt + 32'(num_eff);
      mismatch_cnt <= mis_next;
      // A zero count means nothing has been captured yet (the count saturates, never wraps)
      if (any_mis && (mismatch_cnt == 16'd0)) begin
        cap_pc        <= lane_pc[first_lane];
        cap_waddr     <= lane_waddr[first_lane];
        cap_wdata     <= lane_wdata[first_lane];
        cap_ref_pc    <= head_pc[rank[first_lane]];
        cap_ref_wnum  <= head_wnum[rank[first_lane]];
        cap_ref_wdata <= head_wdata[rank[first_lane]];
      end
    end
  end

  // Test-status FSM; a stopping mismatch outranks a same-cycle done-store
  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_resetn) begin
    if (!mips_cpu_resetn) begin
      state <= ST_RUN;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else if (state == ST_RUN) begin
      if (any_mis && (STOP_ON_MISMATCH != 0)) begin
        state <= ST_FAIL;
        done  <= 1'b1;
        pass  <= 1'b0;
      end else if (done_store) begin
        state <= ST_DONE;
        done  <= 1'b1;
        pass  <= (mis_next == 16'd0);
      end
    end
  end

endmodule
